// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Transmit end of the serial bit link. A WIDTH-bit word is taken over a
// valid/ready handshake and sent one bit per clock on sout. sout_valid
// qualifies each bit. sout_first and sout_last mark the word boundaries.
//
// With LSB_FIRST=1, bit 0 goes out first. A downstream SIPO of the same width
// (din enters at the MSB and shifts toward bit 0) then holds the original word
// after the last bit. With LSB_FIRST=0, bit WIDTH-1 goes out first.
//
// A new word can be accepted while the last bit of the current word is on the
// wire. This gives gapless back-to-back transfers.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; drops any word in flight
//   pdata        parallel word to transmit (WIDTH bits)
//   pdata_valid  pdata is valid; upstream holds it until it is accepted
//   pdata_ready  block accepts pdata this cycle (depends on state only)
//   sout         serial data bit, forced to 0 when sout_valid is low
//   sout_valid   sout carries a bit of a word this cycle
//   sout_first   current bit is the first bit of its word
//   sout_last    current bit is the last bit of its word
//   busy         a word is being shifted out (same as sout_valid)
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pdata_valid,
    output logic             pdata_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             in_shift;
    logic             on_last_bit;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;
    logic             head_bit;

    // The shift direction and the bit presented on the wire are fixed at
    // elaboration time. The bit on sout is always the one at the exit end
    // of shreg.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign head_bit      = shreg_q[0];
        end else begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign head_bit      = shreg_q[WIDTH-1];
        end
    endgenerate

    assign in_shift    = (state_q == ST_SHIFT);
    assign on_last_bit = in_shift && (bit_cnt_q == LAST_CNT);

    // Ready looks only at state and bit_cnt. It never depends on
    // pdata_valid, so there is no combinational path from valid to ready.
    assign pdata_ready = (state_q == ST_IDLE) || on_last_bit;
    assign accept      = pdata_valid && pdata_ready;

    // Next-state logic for the state machine and the datapath.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;

        if (accept) begin
            // Covers both the idle case and a reload on the last bit.
            // A reload on the last bit keeps SHIFT, so there is no bubble.
            state_d   = ST_SHIFT;
            shreg_d   = pdata;
            bit_cnt_d = '0;
        end else if (in_shift) begin
            if (on_last_bit) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end else begin
                shreg_d   = shreg_shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // State registers. Reset has priority over everything, including an
    // asserted pdata_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs. shreg keeps stale bits after a word ends, so sout is gated
    // to 0 outside SHIFT.
    assign sout_valid = in_shift;
    assign busy       = in_shift;
    assign sout       = in_shift && head_bit;
    assign sout_first = in_shift && (bit_cnt_q == '0);
    assign sout_last  = on_last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Two instances share the same stimulus: one with LSB_FIRST=1 and one with
// LSB_FIRST=0. The reference model is a queue of expected wire bits per
// instance. An accepted word appends WIDTH entries. Each clock retires the
// head entry. The model is ready whenever at most one bit remains queued.
// A SIPO on each serial output gives a loopback check of the reassembled word.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pdata_valid = 1'b0;
    logic [W-1:0] pdata = '0;

    logic rdy1, sout1, vld1, first1, last1, busy1;
    logic rdy0, sout0, vld0, first0, last0, busy0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .pdata(pdata), .pdata_valid(pdata_valid),
        .pdata_ready(rdy1), .sout(sout1), .sout_valid(vld1),
        .sout_first(first1), .sout_last(last1), .busy(busy1)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .pdata(pdata), .pdata_valid(pdata_valid),
        .pdata_ready(rdy0), .sout(sout0), .sout_valid(vld0),
        .sout_first(first0), .sout_last(last0), .busy(busy0)
    );

    // Downstream SIPOs: din enters at the MSB and shifts toward bit 0.
    logic [W-1:0] sipo1, sipo0;
    always @(posedge clk) begin
        if (rst) begin
            sipo1 <= '0;
            sipo0 <= '0;
        end else begin
            if (vld1) sipo1 <= {sout1, sipo1[W-1:1]};
            if (vld0) sipo0 <= {sout0, sipo0[W-1:1]};
        end
    end

    typedef struct {
        bit           b;
        bit           first;
        bit           last;
        logic [W-1:0] word;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit           chk_en   = 1'b0;
    bit           exp_sipo = 1'b0;
    logic [W-1:0] exp_word = '0;
    logic [31:0]  log_bits = '0;
    int           log_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    // One clock cycle. Entered and left at a falling edge. Outputs are
    // checked first, then the inputs for the coming rising edge are applied.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
        bit   rdy_m;
        ent_t e;
        rdy_m = (q1.size() <= 1);
        if (chk_en) begin
            check_eq("ready_lsb", 32'(rdy1), 32'(rdy_m));
            check_eq("ready_msb", 32'(rdy0), 32'(rdy_m));
            if (q1.size() > 0) begin
                check_eq("valid_lsb", 32'(vld1), 32'd1);
                check_eq("busy_lsb",  32'(busy1), 32'd1);
                check_eq("sout_lsb",  32'(sout1), 32'(q1[0].b));
                check_eq("first_lsb", 32'(first1), 32'(q1[0].first));
                check_eq("last_lsb",  32'(last1), 32'(q1[0].last));
                check_eq("valid_msb", 32'(vld0), 32'd1);
                check_eq("busy_msb",  32'(busy0), 32'd1);
                check_eq("sout_msb",  32'(sout0), 32'(q0[0].b));
                check_eq("first_msb", 32'(first0), 32'(q0[0].first));
                check_eq("last_msb",  32'(last0), 32'(q0[0].last));
                log_bits = {log_bits[30:0], sout1};
                log_cnt++;
            end else begin
                check_eq("idle_lsb", 32'({vld1, busy1, sout1, first1, last1}), 32'd0);
                check_eq("idle_msb", 32'({vld0, busy0, sout0, first0, last0}), 32'd0);
            end
            if (exp_sipo) begin
                check_eq("sipo_lsb", 32'(sipo1), 32'(exp_word));
                check_eq("sipo_msb", 32'(sipo0), 32'(rev(exp_word)));
            end
        end
        rst         = r;
        pdata_valid = v;
        pdata       = d;
        @(posedge clk);
        exp_sipo = 1'b0;
        if (r) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                void'(q0.pop_front());
                if (e.last) begin
                    exp_sipo = 1'b1;
                    exp_word = e.word;
                end
            end
            if (v && rdy_m) begin
                for (int k = 0; k < W; k++) begin
                    e.first = (k == 0);
                    e.last  = (k == W - 1);
                    e.word  = d;
                    e.b     = d[k];
                    q1.push_back(e);
                    e.b     = d[W-1-k];
                    q0.push_back(e);
                end
            end
        end
        chk_en = 1'b1;
        @(negedge clk);
        $display("[TB] t=%0t rst=%0b v=%0b d=%h | lsb sout=%0b vld=%0b rdy=%0b | msb sout=%0b vld=%0b rdy=%0b",
                 $time, r, v, d, sout1, vld1, rdy1, sout0, vld0, rdy0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    task automatic log_clear();
        log_bits = '0;
        log_cnt  = 0;
    endtask

    initial begin
        bit           v_pend;
        bit           r_rand;
        bit           rdy_pre;
        logic [W-1:0] d_pend;

        @(negedge clk);

        // Reset with pdata_valid held high: nothing may be accepted.
        cycle(1'b1, 1'b1, 4'hF);
        cycle(1'b1, 1'b1, 4'hF);
        idle(2);

        // Single word 0110 -> 0,1,1,0.
        log_clear();
        cycle(1'b0, 1'b1, 4'b0110);
        idle(6);
        check_eq("single_bits", log_bits, 32'b0110);
        check_eq("single_cnt", 32'(log_cnt), 32'd4);

        // Back-to-back words 1010 then 0011 -> 0,1,0,1,1,1,0,0.
        log_clear();
        cycle(1'b0, 1'b1, 4'b1010);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0011);
        idle(6);
        check_eq("b2b_bits", log_bits, 32'b01011100);
        check_eq("b2b_cnt", 32'(log_cnt), 32'd8);

        // Valid pulses on bits 1-2 with new data are ignored.
        log_clear();
        cycle(1'b0, 1'b1, 4'b0110);
        cycle(1'b0, 1'b0, 4'b0110);
        cycle(1'b0, 1'b1, 4'b1111);
        cycle(1'b0, 1'b1, 4'b1001);
        idle(6);
        check_eq("stall_bits", log_bits, 32'b0110);
        check_eq("stall_cnt", 32'(log_cnt), 32'd4);

        // Reset during bit 2, then a clean word 1001.
        cycle(1'b0, 1'b1, 4'b1101);
        idle(2);
        cycle(1'b1, 1'b0, '0);
        log_clear();
        idle(1);
        cycle(1'b0, 1'b1, 4'b1001);
        idle(6);
        check_eq("rst_bits", log_bits, 32'b1001);
        check_eq("rst_cnt", 32'(log_cnt), 32'd4);

        // Loopback through the SIPOs.
        cycle(1'b0, 1'b1, 4'b1101);
        idle(6);
        check_eq("loop_lsb", 32'(sipo1), 32'b1101);
        check_eq("loop_msb", 32'(sipo0), 32'b1011);

        // Random traffic. Upstream holds each word until it is accepted.
        v_pend = 1'b0;
        d_pend = '0;
        for (int n = 0; n < 400; n++) begin
            if (!v_pend && ($urandom_range(0, 2) != 0)) begin
                v_pend = 1'b1;
                d_pend = W'($urandom);
            end
            r_rand  = ($urandom_range(0, 39) == 0);
            rdy_pre = (q1.size() <= 1);
            cycle(r_rand, v_pend, d_pend);
            if (!r_rand && v_pend && rdy_pre) v_pend = 1'b0;
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
